assoc_cache: RTL and testbench
==============================

ASSOC_CACHE -- requirements
Module: assoc_cache

Interface
REQ-001 Parameters (name, default, meaning), one per line; the module SHALL provide:
  ADDR_W  8  byte address width
  DATA_W  8  data word width, one word per line
  SETS    4  number of sets, power of two >= 2
  WAYS    2  associativity, power of two, 2..8
REQ-002 Ports (name  direction  width  meaning); the module SHALL provide:
  clk        in   1       single clock, all logic on rising edge
  rst        in   1       asynchronous, active-low reset
  req_valid  in   1       request present
  req_ready  out  1       request accepted when req_valid && req_ready
  req_we     in   1       1 = write, 0 = read
  req_addr   in   ADDR_W  request address; index = low log2(SETS) bits, tag = remaining bits
  req_wdata  in   DATA_W  write data
  flush      in   1       invalidate all lines
  resp_valid out  1       one-cycle response pulse, no backpressure
  resp_rdata out  DATA_W  read data, or write data echoed for writes
  resp_hit   out  1       1 if request hit the cache
  mem_req    out  1       backing-memory request, held until mem_ack
  mem_we     out  1       backing-memory write
  mem_addr   out  ADDR_W  backing-memory address
  mem_wdata  out  DATA_W  backing-memory write data
  mem_ack    in   1       memory done; mem_rdata valid this cycle for reads
  mem_rdata  in   DATA_W  memory read data
  hit_cnt    out  16      saturating hit counter
  miss_cnt   out  16      saturating miss counter

Function
REQ-003 The FSM SHALL use the states IDLE, LOOKUP, MEM_WAIT, RESP; req_ready SHALL be 1 only in IDLE when flush=0.
REQ-004 On acceptance in IDLE, the block SHALL register addr, we and wdata and go to LOOKUP.
REQ-005 LOOKUP SHALL compare the tag against all WAYS ways of the set; a hit SHALL require valid && tag match in exactly one way.
REQ-006 On a read hit, the block SHALL go to RESP with the cached data; resp_valid SHALL assert 2 cycles after the acceptance edge.
REQ-007 On a read miss, the block SHALL assert mem_req=1, mem_we=0, mem_addr=addr and enter MEM_WAIT. On mem_ack it SHALL fill the victim way (data, tag, valid=1), then go to RESP with mem_rdata and resp_hit=0.
REQ-008 Writes SHALL be write-through and no-write-allocate: mem_req=1, mem_we=1, MEM_WAIT until mem_ack. On a hit, the hit way's data SHALL be updated and resp_hit=1. On a miss, no line SHALL change.
REQ-009 The victim SHALL be the lowest-index invalid way; if none is invalid, it SHALL be the LRU way.
REQ-010 LRU SHALL be true LRU using per-set, per-way age counters of width log2(WAYS). On a hit or fill, the accessed way SHALL go to age 0, ways younger than it SHALL increment, and others SHALL hold. The LRU way SHALL be the one with age WAYS-1. Write misses SHALL NOT touch LRU.
REQ-011 RESP SHALL last one cycle with resp_valid=1, then return to IDLE; resp_rdata/resp_hit SHALL hold until the next response.
REQ-012 hit_cnt/miss_cnt SHALL increment by one per completed request (in RESP) and saturate at 16'hFFFF.
REQ-013 Flush sampled in IDLE SHALL clear all valid bits and reset ages to way index in one cycle; flush has priority over a simultaneous req_valid, which SHALL stay pending.
REQ-014 A flush asserted outside IDLE SHALL be latched and applied on the first IDLE cycle before any new acceptance.
REQ-015 mem_ack in any state other than MEM_WAIT SHALL be ignored.
REQ-016 mem_addr/mem_we/mem_wdata SHALL remain stable while mem_req=1.

Reset
REQ-017 While rst=0, state=IDLE and all valid bits=0; ages[w]=w; counters=0; all outputs=0, including req_ready=0.
REQ-018 Reset mid-transaction SHALL abandon the transaction: no response, mem_req drops immediately, no line updated.
REQ-019 Data and tag arrays SHALL NOT require reset.

Structure
REQ-020 The package cache_pkg SHALL hold the state enum, the 16-bit counter width constant, and the derived index/tag/age width functions.
REQ-021 LRU age update/victim select SHALL be the sub-module cache_lru (one set's ages in, accessed way in, new ages and victim out), instantiated once on the selected set.

Verification (defaults; memory returns mem_rdata = addr, mem_ack 3 cycles after mem_req)
REQ-022 After reset, read 0x15 -> mem_req with mem_addr=0x15; resp_valid with rdata=0x15, hit=0; miss_cnt=1.
REQ-023 Read 0x15 again -> resp_valid 2 cycles after acceptance, rdata=0x15, hit=1, no mem_req; hit_cnt=1.
REQ-024 Read 0x01, 0x05, 0x01, 0x09 (set 1) -> 0x09 evicts 0x05 (LRU); a subsequent read of 0x01 hits and a read of 0x05 misses.
REQ-025 Write 0x01 with data 0xAA while it is cached -> mem write to 0x01, hit=1; a re-read of 0x01 returns 0xAA with no mem_req. Write to uncached 0x02 -> hit=0, and a re-read misses.
REQ-026 Flush during MEM_WAIT together with req_valid on return to IDLE -> flush applied first, req_ready=0 that cycle, and the following read of 0x15 misses.
REQ-027 rst low during MEM_WAIT, then a late mem_ack -> no resp_valid, counters=0, and the next read misses.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared types and width helpers for the set-associative cache.
// The counter width and index/tag/age widths are derived here once.
package cache_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOOKUP,
        MEM_WAIT,
        RESP
    } state_t;

    localparam int CNT_W = 16;

    function automatic int idx_w(input int sets);
        return $clog2(sets);
    endfunction

    function automatic int tag_w(input int addr_w, input int sets);
        return addr_w - $clog2(sets);
    endfunction

    function automatic int age_w(input int ways);
        return $clog2(ways);
    endfunction

endpackage

// File: rtl/cache_lru.sv
// True-LRU age update and victim choice for one set.
// Age 0 is most recent; the way at age WAYS-1 is least recent.
module cache_lru
    import cache_pkg::*;
#(
    parameter int WAYS = 2,
    parameter int AGW  = age_w(WAYS)
) (
    input  logic [WAYS-1:0][AGW-1:0] ages,
    input  logic [WAYS-1:0]          valid,
    input  logic [AGW-1:0]           way,
    output logic [WAYS-1:0][AGW-1:0] new_ages,
    output logic [AGW-1:0]           victim
);

    localparam logic [AGW-1:0] OLDEST = AGW'(WAYS - 1);

    always_comb begin
        new_ages = ages;
        for (int w = 0; w < WAYS; w++) begin
            if (AGW'(w) == way) begin
                new_ages[w] = '0;
            end else if (ages[w] < ages[way]) begin
                new_ages[w] = ages[w] + AGW'(1);
            end
        end
    end

    // Lowest invalid way wins over the LRU way.
    always_comb begin
        victim = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (ages[w] == OLDEST) begin
                victim = AGW'(w);
            end
        end
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid[w]) begin
                victim = AGW'(w);
            end
        end
    end

endmodule

// File: rtl/assoc_cache.sv
// Set-associative write-through, no-write-allocate cache with true LRU.
// One request in flight; misses and all writes go to backing memory.
module assoc_cache
    import cache_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int SETS   = 4,
    parameter int WAYS   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic              flush,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_hit,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [CNT_W-1:0]  hit_cnt,
    output logic [CNT_W-1:0]  miss_cnt
);

    localparam int IW  = idx_w(SETS);
    localparam int TW  = tag_w(ADDR_W, SETS);
    localparam int AGW = age_w(WAYS);

    state_t state;

    logic [ADDR_W-1:0] r_addr;
    logic              r_we;
    logic [DATA_W-1:0] r_wdata;
    logic              r_hit;
    logic [AGW-1:0]    r_way;
    logic              flush_pend;
    logic              ready_q;

    logic [WAYS-1:0]           valid_mem [SETS];
    logic [WAYS-1:0][AGW-1:0]  age_mem   [SETS];
    logic [TW-1:0]             tag_mem   [SETS][WAYS];
    logic [DATA_W-1:0]         data_mem  [SETS][WAYS];

    logic [IW-1:0]            r_set;
    logic [TW-1:0]            r_tag;
    logic [WAYS-1:0]          match;
    logic                     hit;
    logic [AGW-1:0]           hit_way;
    logic [AGW-1:0]           lru_way;
    logic [AGW-1:0]           victim;
    logic [WAYS-1:0][AGW-1:0] new_ages;
    logic [WAYS-1:0][AGW-1:0] init_ages;

    assign r_set = r_addr[IW-1:0];
    assign r_tag = r_addr[ADDR_W-1:IW];

    // A flush arriving this cycle must block acceptance combinationally.
    assign req_ready = ready_q && !flush;

    always_comb begin
        init_ages = '0;
        for (int w = 0; w < WAYS; w++) begin
            init_ages[w] = AGW'(w);
        end
    end

    always_comb begin
        match = '0;
        for (int w = 0; w < WAYS; w++) begin
            match[w] = valid_mem[r_set][w] && (tag_mem[r_set][w] == r_tag);
        end
    end

    assign hit = $onehot(match);

    always_comb begin
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (match[w]) begin
                hit_way = AGW'(w);
            end
        end
    end

    assign lru_way = (state == LOOKUP) ? hit_way : r_way;

    cache_lru #(
        .WAYS (WAYS),
        .AGW  (AGW)
    ) u_lru (
        .ages     (age_mem[r_set]),
        .valid    (valid_mem[r_set]),
        .way      (lru_way),
        .new_ages (new_ages),
        .victim   (victim)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            r_addr     <= '0;
            r_we       <= 1'b0;
            r_wdata    <= '0;
            r_hit      <= 1'b0;
            r_way      <= '0;
            flush_pend <= 1'b0;
            ready_q    <= 1'b0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_hit   <= 1'b0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            hit_cnt    <= '0;
            miss_cnt   <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid_mem[s] <= '0;
                age_mem[s]   <= init_ages;
            end
        end else begin
            resp_valid <= 1'b0;
            if (state != IDLE && flush) begin
                flush_pend <= 1'b1;
            end
            unique case (state)
                IDLE: begin
                    if (flush || flush_pend) begin
                        flush_pend <= 1'b0;
                        ready_q    <= 1'b1;
                        for (int s = 0; s < SETS; s++) begin
                            valid_mem[s] <= '0;
                            age_mem[s]   <= init_ages;
                        end
                    end else if (req_valid && req_ready) begin
                        r_addr  <= req_addr;
                        r_we    <= req_we;
                        r_wdata <= req_wdata;
                        ready_q <= 1'b0;
                        state   <= LOOKUP;
                    end else begin
                        ready_q <= 1'b1;
                    end
                end
                LOOKUP: begin
                    r_hit <= hit;
                    r_way <= hit ? hit_way : victim;
                    if (!r_we && hit) begin
                        age_mem[r_set] <= new_ages;
                        resp_rdata     <= data_mem[r_set][hit_way];
                        resp_hit       <= 1'b1;
                        resp_valid     <= 1'b1;
                        state          <= RESP;
                    end else begin
                        mem_req   <= 1'b1;
                        mem_we    <= r_we;
                        mem_addr  <= r_addr;
                        mem_wdata <= r_wdata;
                        state     <= MEM_WAIT;
                    end
                end
                MEM_WAIT: begin
                    if (mem_ack) begin
                        mem_req    <= 1'b0;
                        mem_we     <= 1'b0;
                        resp_valid <= 1'b1;
                        state      <= RESP;
                        if (!r_we) begin
                            valid_mem[r_set][r_way] <= 1'b1;
                            age_mem[r_set]          <= new_ages;
                            resp_rdata              <= mem_rdata;
                            resp_hit                <= 1'b0;
                        end else begin
                            resp_rdata <= r_wdata;
                            resp_hit   <= r_hit;
                            if (r_hit) begin
                                age_mem[r_set] <= new_ages;
                            end
                        end
                    end
                end
                RESP: begin
                    if (resp_hit) begin
                        if (hit_cnt != '1) begin
                            hit_cnt <= hit_cnt + CNT_W'(1);
                        end
                    end else if (miss_cnt != '1) begin
                        miss_cnt <= miss_cnt + CNT_W'(1);
                    end
                    ready_q <= !(flush || flush_pend);
                    state   <= IDLE;
                end
            endcase
        end
    end

    // Tag/data storage carries no reset; valid bits guard its contents.
    always_ff @(posedge clk) begin
        if (state == MEM_WAIT && mem_ack) begin
            if (!r_we) begin
                tag_mem[r_set][r_way]  <= r_tag;
                data_mem[r_set][r_way] <= mem_rdata;
            end else if (r_hit) begin
                data_mem[r_set][r_way] <= r_wdata;
            end
        end
    end

endmodule

// File: tb/tb_assoc_cache.sv
// Directed bench for assoc_cache with a response scoreboard.
// Memory answers mem_rdata = mem_addr, acking 3 cycles after mem_req.
module tb_assoc_cache;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [7:0]  req_addr;
    logic [7:0]  req_wdata;
    logic        flush;
    logic        resp_valid;
    logic [7:0]  resp_rdata;
    logic        resp_hit;
    logic        mem_req;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_ack;
    logic [7:0]  mem_rdata;
    logic [15:0] hit_cnt;
    logic [15:0] miss_cnt;

    logic        model_ack;
    logic        force_ack;
    logic        mem_en;

    int          tests;
    int          fails;
    int          mem_reqs;
    int          cnt;
    logic [7:0]  last_addr;
    logic        last_we;
    logic [7:0]  last_wdata;

    typedef struct packed {
        logic [7:0] rdata;
        logic       hit;
    } want_t;

    want_t want_q[$];

    assign mem_ack = model_ack | force_ack;

    assoc_cache dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .flush      (flush),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_hit   (resp_hit),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .hit_cnt    (hit_cnt),
        .miss_cnt   (miss_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] want);
        tests++;
        assert (obs === want) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
        end
    endtask

    // Backing memory: fixed 3-cycle ack, address echoed as data.
    initial begin
        model_ack = 1'b0;
        mem_rdata = '0;
        cnt       = 0;
        forever begin
            @(negedge clk);
            if (mem_req) begin
                if (cnt == 0) begin
                    mem_reqs++;
                    last_addr  = mem_addr;
                    last_we    = mem_we;
                    last_wdata = mem_wdata;
                end else begin
                    check("mem_addr_stable", 32'(mem_addr), 32'(last_addr));
                    check("mem_we_stable", 32'(mem_we), 32'(last_we));
                    check("mem_wdata_stable", 32'(mem_wdata), 32'(last_wdata));
                end
                cnt++;
                model_ack = mem_en && (cnt == 3);
                mem_rdata = mem_addr;
            end else begin
                cnt       = 0;
                model_ack = 1'b0;
            end
        end
    end

    initial begin
        want_t w;
        forever begin
            @(negedge clk);
            if (resp_valid) begin
                check("resp_expected", 32'(want_q.size() != 0), 32'(1));
                if (want_q.size() != 0) begin
                    w = want_q.pop_front();
                    check("resp_rdata", 32'(resp_rdata), 32'(w.rdata));
                    check("resp_hit", 32'(resp_hit), 32'(w.hit));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic send(input logic we, input logic [7:0] a,
                        input logic [7:0] d, input logic [7:0] er,
                        input logic eh, input int exp_mem);
        int k;
        int m0;
        int lat;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        req_valid = 1'b1;
        k = 0;
        while (!req_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("accept", 32'(req_ready), 32'(1));
        if (!req_ready) begin
            req_valid = 1'b0;
            return;
        end
        m0 = mem_reqs;
        want_q.push_back('{rdata: er, hit: eh});
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("resp_seen", 32'(resp_valid), 32'(1));
        if (exp_mem == 0) begin
            check("hit_latency", 32'(lat), 32'(2));
        end
        check("mem_reqs", 32'(mem_reqs - m0), 32'(exp_mem));
        if (exp_mem != 0) begin
            check("mem_addr", 32'(last_addr), 32'(a));
            check("mem_we", 32'(last_we), 32'(we));
            if (we) begin
                check("mem_wdata", 32'(last_wdata), 32'(d));
            end
        end
        @(negedge clk);
    endtask

    initial begin
        int k;
        int n;
        tests     = 0;
        fails     = 0;
        mem_reqs  = 0;
        rst       = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        flush     = 1'b0;
        force_ack = 1'b0;
        mem_en    = 1'b1;

        repeat (3) @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'(0));
        check("rst_resp_valid", 32'(resp_valid), 32'(0));
        check("rst_mem_req", 32'(mem_req), 32'(0));
        check("rst_hit_cnt", 32'(hit_cnt), 32'(0));
        check("rst_miss_cnt", 32'(miss_cnt), 32'(0));
        check("rst_resp_rdata", 32'(resp_rdata), 32'(0));
        rst = 1'b1;
        @(negedge clk);

        send(1'b0, 8'h15, 8'h00, 8'h15, 1'b0, 1);
        check("miss_cnt_1", 32'(miss_cnt), 32'(1));
        send(1'b0, 8'h15, 8'h00, 8'h15, 1'b1, 0);
        check("hit_cnt_1", 32'(hit_cnt), 32'(1));

        // Set 1 sequence: 0x09 must evict 0x05 as the LRU line.
        send(1'b0, 8'h01, 8'h00, 8'h01, 1'b0, 1);
        send(1'b0, 8'h05, 8'h00, 8'h05, 1'b0, 1);
        send(1'b0, 8'h01, 8'h00, 8'h01, 1'b1, 0);
        send(1'b0, 8'h09, 8'h00, 8'h09, 1'b0, 1);
        send(1'b0, 8'h01, 8'h00, 8'h01, 1'b1, 0);
        send(1'b0, 8'h05, 8'h00, 8'h05, 1'b0, 1);

        send(1'b1, 8'h01, 8'hAA, 8'hAA, 1'b1, 1);
        send(1'b0, 8'h01, 8'h00, 8'hAA, 1'b1, 0);
        send(1'b1, 8'h02, 8'h5C, 8'h5C, 1'b0, 1);
        send(1'b0, 8'h02, 8'h00, 8'h02, 1'b0, 1);
        check("miss_cnt_7", 32'(miss_cnt), 32'(7));
        check("hit_cnt_5", 32'(hit_cnt), 32'(5));

        // Flush raised in MEM_WAIT with a request queued behind it.
        req_we    = 1'b0;
        req_addr  = 8'h15;
        req_valid = 1'b1;
        k = 0;
        while (!req_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("fl_accept", 32'(req_ready), 32'(1));
        want_q.push_back('{rdata: 8'h15, hit: 1'b0});
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        check("fl_mem_req", 32'(mem_req), 32'(1));
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        k = 0;
        while (!resp_valid && k < 40) begin
            @(negedge clk);
            k++;
        end
        check("fl_resp", 32'(resp_valid), 32'(1));
        req_valid = 1'b1;
        @(negedge clk);
        check("fl_ready_blocked", 32'(req_ready), 32'(0));
        send(1'b0, 8'h15, 8'h00, 8'h15, 1'b0, 1);
        check("miss_cnt_9", 32'(miss_cnt), 32'(9));
        check("hit_cnt_5b", 32'(hit_cnt), 32'(5));

        // Reset while waiting on memory, then a stray ack.
        mem_en    = 1'b0;
        req_we    = 1'b0;
        req_addr  = 8'h22;
        req_valid = 1'b1;
        k = 0;
        while (!req_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("rs_accept", 32'(req_ready), 32'(1));
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rs_mem_req_pre", 32'(mem_req), 32'(1));
        rst = 1'b0;
        #1;
        check("rs_mem_req", 32'(mem_req), 32'(0));
        check("rs_req_ready", 32'(req_ready), 32'(0));
        check("rs_resp_valid", 32'(resp_valid), 32'(0));
        check("rs_hit_cnt", 32'(hit_cnt), 32'(0));
        check("rs_miss_cnt", 32'(miss_cnt), 32'(0));
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        force_ack = 1'b1;
        @(negedge clk);
        force_ack = 1'b0;
        n = 0;
        repeat (6) begin
            @(negedge clk);
            if (resp_valid) n++;
        end
        check("late_ack_no_resp", 32'(n), 32'(0));
        check("late_ack_miss_cnt", 32'(miss_cnt), 32'(0));
        mem_en = 1'b1;
        send(1'b0, 8'h22, 8'h00, 8'h22, 1'b0, 1);
        send(1'b0, 8'h15, 8'h00, 8'h15, 1'b0, 1);
        check("post_rst_miss_cnt", 32'(miss_cnt), 32'(2));
        check("post_rst_hit_cnt", 32'(hit_cnt), 32'(0));

        repeat (2) @(negedge clk);
        check("queue_empty", 32'(want_q.size()), 32'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
